pebble_mc_core: RTL and testbench

Parametrised multicycle Pebble core: the next generation of the single-cycle Pebble top level. It keeps the 9-bit Pebble instruction format, the 4-entry register file and the start/done contract. It adds three things: a data width and PC width set by parameters, a FETCH/EXEC/MEM state machine, and a data-memory request/acknowledge handshake so memories with variable latency can be attached. Instruction memory and data memory sit outside this block; the core drives them through its ports.

---
 rtl/pebble_mc_core.sv | 169 ++++++++++++++++
 tb/tb_pebble_mc_core.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pebble_mc_core.sv
`default_nettype none
// =====================================================================
// pebble_mc_core : multicycle Pebble core (FETCH/EXEC/MEM) with a
//                  req/ack data-memory port for variable-latency memory
// Rev 1.0
// =====================================================================
module pebble_mc_core #(
  parameter int DW  = 8,
  parameter int PCW = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           done,
  output logic           busy,
  output logic [PCW-1:0] imem_addr,
  input  logic [8:0]     imem_data,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic           dmem_ack,
  input  logic [DW-1:0]  dmem_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [8:0]     ir_q, ir_d;
  logic [DW-1:0]  rf_q [4];
  logic [DW-1:0]  rf_d [4];
  logic           req_q, req_d;
  logic           we_q, we_d;
  logic [DW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;

  logic [2:0]     op;
  logic [1:0]     rd, rs, li_rd, rt;
  logic [DW-1:0]  src_a, src_b, alu;
  logic [PCW-1:0] pc_inc;
  logic           beq_taken;

  // rd/rs double as ra/rb for memory ops and BEQ
  assign op        = ir_q[6:4];
  assign rd        = ir_q[3:2];
  assign rs        = ir_q[1:0];
  assign li_rd     = ir_q[6:5];
  assign rt        = ir_q[5:4];
  assign src_a     = rf_q[rd];
  assign src_b     = rf_q[rs];
  assign pc_inc    = pc_q + PCW'(1);
  assign beq_taken = (src_a == src_b);

  always_comb begin
    alu = src_b;
    case (op)
      3'b000:  alu = src_a + src_b;
      3'b001:  alu = src_a - src_b;
      3'b010:  alu = src_a & src_b;
      3'b011:  alu = src_a | src_b;
      3'b100:  alu = src_a ^ src_b;
      3'b101:  alu = {src_a[DW-2:0], 1'b0};
      3'b110:  alu = {1'b0, src_a[DW-1:1]};
      default: alu = src_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (start) state_d = S_FETCH;
      S_FETCH:        state_d = S_EXEC;
      S_EXEC: begin
        if (ir_q[8:7] == 2'b10)
          state_d = S_MEM;
        else if (ir_q[8:7] == 2'b11 && ir_q[6])
          state_d = S_HALT;
        else
          state_d = S_FETCH;
      end
      S_MEM:          if (dmem_ack) state_d = S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    for (int i = 0; i < 4; i++) rf_d[i] = rf_q[i];
    case (state_q)
      S_IDLE, S_HALT: if (start) pc_d = '0;
      S_FETCH:        ir_d = imem_data;
      S_EXEC: begin
        case (ir_q[8:7])
          2'b00: begin
            rf_d[rd] = alu;
            pc_d     = pc_inc;
          end
          2'b01: begin
            rf_d[li_rd] = DW'(ir_q[4:0]);
            pc_d        = pc_inc;
          end
          2'b10: begin
            // memory-port registers stay frozen for the whole MEM wait
            req_d   = 1'b1;
            we_d    = ~ir_q[6];
            addr_d  = src_b;
            wdata_d = src_a;
          end
          default: begin
            if (!ir_q[6]) pc_d = beq_taken ? PCW'(rf_q[rt]) : pc_inc;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          req_d = 1'b0;
          if (!we_q) rf_d[rd] = dmem_rdata;
          pc_d = pc_inc;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    done = (state_q == S_HALT);
    busy = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);
  end

  assign imem_addr  = pc_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_pebble_mc_core.sv
`default_nettype none
// tb_pebble_mc_core : scoreboard bench driving two core configurations,
// DW=8/PCW=10 (u0) and DW=16/PCW=4 (u1), with directed Pebble programs.
module tb_pebble_mc_core;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MOV = 3'd7;

  typedef struct {
    int          dut;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] pc;
    int          wait_n;
    logic [15:0] rdata;
  } mem_exp_t;

  typedef struct {
    int dut;
    int edges;
  } done_exp_t;

  mem_exp_t  mq[$];
  done_exp_t dq[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  start_v = 2'b00;
  logic [1:0]  ack_v = 2'b00;
  logic [15:0] rdata_w [2];

  logic        done0, busy0, req0, we0;
  logic [9:0]  ia0;
  logic [8:0]  id0;
  logic [7:0]  addr0, wdata0;
  logic        done1, busy1, req1, we1;
  logic [3:0]  ia1;
  logic [8:0]  id1;
  logic [15:0] addr1, wdata1;

  logic [8:0]  imem0 [1024];
  logic [8:0]  imem1 [16];

  logic [15:0] m_addr [2];
  logic [15:0] m_wdata[2];
  logic [15:0] m_pc   [2];
  logic        m_req  [2];
  logic        m_we   [2];
  logic        m_done [2];
  logic        m_busy [2];

  always #5 clk = ~clk;

  assign id0 = imem0[ia0];
  assign id1 = imem1[ia1];

  assign m_addr[0]  = {8'h00, addr0};
  assign m_addr[1]  = addr1;
  assign m_wdata[0] = {8'h00, wdata0};
  assign m_wdata[1] = wdata1;
  assign m_pc[0]    = {6'h00, ia0};
  assign m_pc[1]    = {12'h000, ia1};
  assign m_req[0]   = req0;
  assign m_req[1]   = req1;
  assign m_we[0]    = we0;
  assign m_we[1]    = we1;
  assign m_done[0]  = done0;
  assign m_done[1]  = done1;
  assign m_busy[0]  = busy0;
  assign m_busy[1]  = busy1;

  pebble_mc_core #(.DW(8), .PCW(10)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .done(done0), .busy(busy0),
    .imem_addr(ia0), .imem_data(id0),
    .dmem_req(req0), .dmem_we(we0), .dmem_addr(addr0), .dmem_wdata(wdata0),
    .dmem_ack(ack_v[0]), .dmem_rdata(rdata_w[0][7:0])
  );

  pebble_mc_core #(.DW(16), .PCW(4)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .done(done1), .busy(busy1),
    .imem_addr(ia1), .imem_data(id1),
    .dmem_req(req1), .dmem_we(we1), .dmem_addr(addr1), .dmem_wdata(wdata1),
    .dmem_ack(ack_v[1]), .dmem_rdata(rdata_w[1])
  );

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", name, d, act, exp);
    end
  endtask

  function automatic logic [8:0] f_r(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
    return {2'b00, op, rd, rs};
  endfunction
  function automatic logic [8:0] f_li(input logic [1:0] rd, input logic [4:0] imm);
    return {2'b01, rd, imm};
  endfunction
  function automatic logic [8:0] f_ld(input logic [1:0] rd, input logic [1:0] ra);
    return {3'b101, 2'b00, rd, ra};
  endfunction
  function automatic logic [8:0] f_st(input logic [1:0] rd, input logic [1:0] ra);
    return {3'b100, 2'b00, rd, ra};
  endfunction
  function automatic logic [8:0] f_beq(input logic [1:0] rt, input logic [1:0] ra, input logic [1:0] rb);
    return {3'b110, rt, ra, rb};
  endfunction
  function automatic logic [8:0] f_done();
    return 9'b111_000000;
  endfunction

  task automatic clear_imem(input int d);
    if (d == 0) for (int i = 0; i < 1024; i++) imem0[i] = 9'h000;
    else        for (int i = 0; i < 16; i++)   imem1[i] = 9'h000;
  endtask

  task automatic put(input int d, input int a, input logic [8:0] ins);
    logic [9:0] ax;
    ax = a[9:0];
    if (d == 0) imem0[ax] = ins;
    else        imem1[ax[3:0]] = ins;
  endtask

  task automatic push_mem(input int d, input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] pc, input int wait_n, input logic [15:0] rdata);
    mem_exp_t e;
    e.dut = d; e.we = we; e.addr = addr; e.wdata = wdata; e.pc = pc; e.wait_n = wait_n; e.rdata = rdata;
    mq.push_back(e);
  endtask

  // Memory responder + monitor: checks every MEM cycle against the queue head, acks after wait_n cycles.
  int   cnt  [2];
  int   wcnt [2];
  bit   run  [2];
  logic done_prev [2];
  initial for (int d = 0; d < 2; d++) begin
    cnt[d] = 0; wcnt[d] = 0; run[d] = 1'b0; done_prev[d] = 1'b0; rdata_w[d] = 16'h0;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        ack_v[d] = 1'b0;
        wcnt[d]  = 0;
        run[d]   = 1'b0;
      end else if (m_req[d]) begin
        if (mq.size() == 0 || mq[0].dut != d) begin
          n_checks++;
          n_fail++;
          ack_v[d] = 1'b0;
          $display("FAIL unexpected_req dut%0d: got request addr %0h, expected no request", d, m_addr[d]);
        end else begin
          check("mem_we", d, 32'(m_we[d]), 32'(mq[0].we));
          check("mem_addr", d, 32'(m_addr[d]), 32'(mq[0].addr));
          if (mq[0].we) check("mem_wdata", d, 32'(m_wdata[d]), 32'(mq[0].wdata));
          check("mem_pc", d, 32'(m_pc[d]), 32'(mq[0].pc));
          if (wcnt[d] == mq[0].wait_n) begin
            ack_v[d]   = 1'b1;
            rdata_w[d] = mq[0].rdata;
            void'(mq.pop_front());
            wcnt[d] = 0;
          end else begin
            ack_v[d] = 1'b0;
            wcnt[d]++;
          end
        end
      end else begin
        ack_v[d] = 1'b0;
        wcnt[d]  = 0;
      end

      if (run[d]) begin
        cnt[d]++;
        if (m_done[d] && !done_prev[d]) begin
          if (dq.size() == 0 || dq[0].dut != d) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done dut%0d: got done after %0d edges, expected none", d, cnt[d]);
          end else begin
            check("done_edges", d, 32'(cnt[d]), 32'(dq[0].edges));
            void'(dq.pop_front());
          end
          run[d] = 1'b0;
        end else if (!m_done[d]) begin
          check("busy_running", d, 32'(m_busy[d]), 32'd1);
        end
      end
      if (!reset && start_v[d] && !m_busy[d]) begin
        run[d] = 1'b1;
        cnt[d] = -1;
      end
      done_prev[d] = m_done[d];
    end
  end

  task automatic run_prog(input int d, input int edges, input int pulse_k);
    done_exp_t e;
    bit seen;
    seen = 1'b0;
    e.dut = d; e.edges = edges;
    dq.push_back(e);
    @(posedge clk); #1 start_v[d] = 1'b1;
    @(posedge clk); #1 start_v[d] = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(posedge clk); #1;
      start_v[d] = (k == pulse_k) && !m_done[d];
      if (m_done[d]) seen = 1'b1;
    end
    start_v[d] = 1'b0;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout dut%0d: done never rose, expected after %0d edges", d, edges);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      mq.delete();
      dq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag, input int d);
    check({tag, "_done"}, d, 32'(m_done[d]), 32'd0);
    check({tag, "_busy"}, d, 32'(m_busy[d]), 32'd0);
    check({tag, "_req"},  d, 32'(m_req[d]),  32'd0);
  endtask

  initial begin
    bit got;
    clear_imem(0);
    clear_imem(1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int d = 0; d < 2; d++) begin
      check_idle_outputs("rst", d);
      check("rst_we",    d, 32'(m_we[d]),    32'd0);
      check("rst_addr",  d, 32'(m_addr[d]),  32'd0);
      check("rst_wdata", d, 32'(m_wdata[d]), 32'd0);
      check("rst_pc",    d, 32'(m_pc[d]),    32'd0);
    end

    // Basic program: LI r0,5; LI r1,3; ADD; LI r2,16; ST r0->[r2]; DONE
    clear_imem(0);
    put(0, 0, f_li(2'd0, 5'd5));
    put(0, 1, f_li(2'd1, 5'd3));
    put(0, 2, f_r(OP_ADD, 2'd0, 2'd1));
    put(0, 3, f_li(2'd2, 5'd16));
    put(0, 4, f_st(2'd0, 2'd2));
    put(0, 5, f_done());
    push_mem(0, 1'b1, 16'h0010, 16'h0008, 16'd4, 0, 16'h0000);
    run_prog(0, 13, -1);

    // Wait states: LD r3<-[r2] acked after 3 waits, then store r3 back
    clear_imem(0);
    put(0, 0, f_ld(2'd3, 2'd2));
    put(0, 1, f_st(2'd3, 2'd2));
    put(0, 2, f_done());
    push_mem(0, 1'b0, 16'h0010, 16'h0000, 16'd0, 3, 16'h00A5);
    push_mem(0, 1'b1, 16'h0010, 16'h00A5, 16'd1, 0, 16'h0000);
    run_prog(0, 11, -1);

    // Branches: taken to r2=0x20, then not taken; start pulsed while busy
    clear_imem(0);
    put(0, 0, f_li(2'd0, 5'd7));
    put(0, 1, f_li(2'd1, 5'd7));
    put(0, 2, f_r(OP_ADD, 2'd2, 2'd2));
    put(0, 3, f_beq(2'd2, 2'd0, 2'd1));
    put(0, 4, f_done());
    put(0, 32, f_li(2'd1, 5'd6));
    put(0, 33, f_beq(2'd2, 2'd0, 2'd1));
    put(0, 34, f_st(2'd1, 2'd2));
    put(0, 35, f_done());
    push_mem(0, 1'b1, 16'h0020, 16'h0006, 16'h0022, 0, 16'h0000);
    run_prog(0, 17, 3);

    // Reset while a load waits in MEM with no ack
    clear_imem(0);
    put(0, 0, f_ld(2'd3, 2'd0));
    put(0, 1, f_done());
    push_mem(0, 1'b0, 16'h0007, 16'h0000, 16'd0, 1000, 16'h005A);
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      if (m_req[0]) got = 1'b1;
    end
    check("mem_req_seen", 0, 32'(got), 32'd1);
    repeat (2) @(posedge clk);
    #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    mq.delete();
    check_idle_outputs("midrst", 0);

    // Registers cleared by reset: store r0->[r1], r2->[r3]
    clear_imem(0);
    put(0, 0, f_st(2'd0, 2'd1));
    put(0, 1, f_st(2'd2, 2'd3));
    put(0, 2, f_done());
    push_mem(0, 1'b1, 16'h0000, 16'h0000, 16'd0, 0, 16'h0000);
    push_mem(0, 1'b1, 16'h0000, 16'h0000, 16'd1, 0, 16'h0000);
    run_prog(0, 8, -1);

    // DW=16, PCW=4: truncated branch target, SUB 0-1, LI 31
    clear_imem(1);
    put(1, 0, f_li(2'd2, 5'd19));
    put(1, 1, f_beq(2'd2, 2'd0, 2'd0));
    put(1, 2, f_done());
    put(1, 3, f_li(2'd1, 5'd1));
    put(1, 4, f_r(OP_SUB, 2'd0, 2'd1));
    put(1, 5, f_st(2'd0, 2'd2));
    put(1, 6, f_li(2'd3, 5'd31));
    put(1, 7, f_st(2'd3, 2'd2));
    put(1, 8, f_done());
    push_mem(1, 1'b1, 16'h0013, 16'hFFFF, 16'd5, 0, 16'h0000);
    push_mem(1, 1'b1, 16'h0013, 16'h001F, 16'd7, 0, 16'h0000);
    run_prog(1, 18, -1);

    // Build 0x8001, then SHR and SHL it
    clear_imem(1);
    put(1, 0, f_r(OP_MOV, 2'd3, 2'd0));
    put(1, 1, f_r(OP_SHR, 2'd3, 2'd0));
    put(1, 2, f_r(OP_XOR, 2'd3, 2'd0));
    put(1, 3, f_r(OP_OR,  2'd3, 2'd1));
    put(1, 4, f_r(OP_MOV, 2'd2, 2'd3));
    put(1, 5, f_r(OP_SHR, 2'd2, 2'd0));
    put(1, 6, f_r(OP_SHL, 2'd3, 2'd0));
    put(1, 7, f_st(2'd2, 2'd3));
    put(1, 8, f_st(2'd3, 2'd1));
    put(1, 9, f_done());
    push_mem(1, 1'b1, 16'h0002, 16'h4000, 16'd7, 0, 16'h0000);
    push_mem(1, 1'b1, 16'h0001, 16'h0002, 16'd8, 0, 16'h0000);
    run_prog(1, 22, -1);

    // PC wrap: jump to 15, LI there, next fetch must be address 0
    clear_imem(1);
    put(1, 0, f_li(2'd3, 5'd15));
    put(1, 1, f_li(2'd1, 5'd0));
    put(1, 2, f_li(2'd0, 5'd0));
    put(1, 3, f_done());
    run_prog(1, 8, -1);
    clear_imem(1);
    put(1, 0, f_beq(2'd3, 2'd1, 2'd0));
    put(1, 1, f_st(2'd1, 2'd2));
    put(1, 2, f_done());
    put(1, 15, f_li(2'd1, 5'd9));
    push_mem(1, 1'b1, 16'h4000, 16'h0009, 16'd1, 0, 16'h0000);
    run_prog(1, 11, -1);

    check("mem_queue_left", 0, 32'(mq.size()), 32'd0);
    check("done_queue_left", 0, 32'(dq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
